spi_axis_packer: RTL and testbench

- Downstream stage of the SPI ADC front end.
- Captures each 24-bit ADS1256 conversion result when the transaction layer flags it ready.
- Sign-extends each result to 32 bits and buffers it in a small FIFO.
- Presents the buffered results as an AXI4-Stream master with framed tlast, plus overflow accounting when the sink stalls.

---
 rtl/spi_axis_packer.sv | 123 ++++++++++++
 tb/tb_spi_axis_packer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_axis_packer.sv
// Packs 24-bit ADC samples into a FWFT FIFO and streams them out as framed AXI4-Stream.
// Optional SPI_AXIS_SEQ_TAG_EN puts an 8-bit sequence tag in tdata[31:24].
module spi_axis_packer #(
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 64,
  parameter int OVF_WIDTH = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_L_i,
  input  logic                   sample_valid_i,
  input  logic [23:0]            sample_i,
  input  logic                   enable_i,
  output logic [31:0]            m_axis_tdata_o,
  output logic                   m_axis_tvalid_o,
  input  logic                   m_axis_tready_i,
  output logic                   m_axis_tlast_o,
  output logic [$clog2(DEPTH):0] fill_level_o,
  output logic [OVF_WIDTH-1:0]   overflow_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] FLAST = FW'(FRAME_LEN - 1);

  logic [31:0]          mem_q [DEPTH];
  logic [AW:0]          wptr_q, wptr_d;
  logic [AW:0]          rptr_q, rptr_d;
  logic [AW:0]          rnext;
  logic [AW:0]          fill_q, fill_d;
  logic [31:0]          head_q, head_d;
  logic [OVF_WIDTH-1:0] ovf_q, ovf_d;
  logic [FW-1:0]        frm_q, frm_d;
  logic [31:0]          wdata;
  logic                 empty, full;
  logic                 take, push, pop, drop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign take  = sample_valid_i & enable_i;
  assign pop   = ~empty & m_axis_tready_i;
  assign push  = take & (~full | pop);
  assign drop  = take & full & ~pop;
  assign rnext = rptr_q + 1'b1;

`ifdef SPI_AXIS_SEQ_TAG_EN
  logic [7:0] tag_q;

  // Dropped samples advance the tag too, exposing gaps downstream
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      tag_q <= '0;
    end else if (take) begin
      tag_q <= tag_q + 8'd1;
    end
  end

  assign wdata = {tag_q, sample_i};
`else
  assign wdata = {{8{sample_i[23]}}, sample_i};
`endif

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;
    head_d = head_q;
    ovf_d  = ovf_q;
    frm_d  = frm_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rnext;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    // Head register tracks the word at the read pointer after this cycle
    if (pop) begin
      if (fill_q == (AW+1)'(1)) begin
        if (push) head_d = wdata;
      end else begin
        head_d = mem_q[rnext[AW-1:0]];
      end
    end else if (empty && push) begin
      head_d = wdata;
    end
    if (drop && ovf_q != '1) ovf_d = ovf_q + 1'b1;
    if (pop) begin
      frm_d = (frm_q == FLAST) ? '0 : frm_q + 1'b1;
    end else if (!enable_i && empty) begin
      frm_d = '0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
      head_q <= '0;
      ovf_q  <= '0;
      frm_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
      head_q <= head_d;
      ovf_q  <= ovf_d;
      frm_q  <= frm_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign m_axis_tvalid_o  = ~empty;
  assign m_axis_tdata_o   = head_q;
  assign m_axis_tlast_o   = ~empty && (frm_q == FLAST);
  assign fill_level_o     = fill_q;
  assign overflow_count_o = ovf_q;

endmodule

// File: tb/tb_spi_axis_packer.sv
// Scoreboard bench for spi_axis_packer (DEPTH=16, FRAME_LEN=4).
module tb_spi_axis_packer;

  localparam int DEPTH = 16;
  localparam int FL    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] sample = '0;
  logic        enable = 1'b0;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        tlast;
  logic [4:0]  fill;
  logic [15:0] ovf;

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  int exp_ovf = 0;
  logic [7:0] etag = '0;
  int mf = 0;
  logic hold = 1'b0;
  logic [31:0] hd;
  logic hl;

  always #5 clk = ~clk;

  spi_axis_packer #(.DEPTH(DEPTH), .FRAME_LEN(FL), .OVF_WIDTH(16)) dut (
    .clock_i          (clk),
    .reset_L_i        (rst_n),
    .sample_valid_i   (sample_valid),
    .sample_i         (sample),
    .enable_i         (enable),
    .m_axis_tdata_o   (tdata),
    .m_axis_tvalid_o  (tvalid),
    .m_axis_tready_i  (tready),
    .m_axis_tlast_o   (tlast),
    .fill_level_o     (fill),
    .overflow_count_o (ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      mf = 0;
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stable_valid", {31'd0, tvalid}, 32'd1);
        chk("stable_data", tdata, hd);
        chk("stable_last", {31'd0, tlast}, {31'd0, hl});
      end
      if (tvalid && tready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", tdata, 32'hDEADBEEF);
        end else begin
          chk("beat_data", tdata, q.pop_front());
          chk("beat_last", {31'd0, tlast}, {31'd0, mf == FL-1});
          mf = (mf == FL-1) ? 0 : mf + 1;
        end
      end else if (!enable && !tvalid) begin
        mf = 0;
      end
      hold = tvalid && !tready;
      hd = tdata;
      hl = tlast;
    end
  end

  // Called at posedge+1; inputs are sampled at the next posedge
  task automatic drive(input logic [23:0] s, input logic vld, input logic rdy);
    logic [31:0] ed;
    sample_valid = vld;
    sample = s;
    tready = rdy;
    if (vld && enable) begin
`ifdef SPI_AXIS_SEQ_TAG_EN
      ed = {etag, s};
      etag = etag + 8'd1;
`else
      ed = {{8{s[23]}}, s};
`endif
      if (q.size() < DEPTH || (rdy && q.size() > 0)) q.push_back(ed);
      else exp_ovf++;
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    tready = 1'b1;
    while (q.size() != 0 && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words left, expected 0", q.size());
    end
    drive('0, 1'b0, 1'b1);
    chk("drained_fill", {27'd0, fill}, 32'd0);
    chk("drained_valid", {31'd0, tvalid}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, tvalid}, 32'd0);
    chk("rst_last", {31'd0, tlast}, 32'd0);
    chk("rst_data", tdata, 32'd0);
    chk("rst_fill", {27'd0, fill}, 32'd0);
    chk("rst_ovf", {16'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;

    // Single negative sample, one-cycle latency
    drive(24'h800001, 1'b1, 1'b1);
    chk("lat_valid", {31'd0, tvalid}, 32'd1);
    chk("lat_fill", {27'd0, fill}, 32'd1);
    chk("lat_data", tdata, 32'hFF800001);
    drive('0, 1'b0, 1'b1);
    chk("single_fill", {27'd0, fill}, 32'd0);

    // Disabled: clears frame, ignores samples
    enable = 1'b0;
    drive(24'h000123, 1'b1, 1'b1);
    drive(24'h000456, 1'b1, 1'b1);
    chk("dis_fill", {27'd0, fill}, 32'd0);
    chk("dis_ovf", {16'd0, ovf}, 32'd0);
    enable = 1'b1;

    // Framing: tlast on 4 and 8
    for (int i = 1; i <= 8; i++) drive(24'(i), 1'b1, 1'b1);
    drain(20);

    // Overflow with stalled sink
    for (int i = 1; i <= DEPTH + 3; i++) drive(24'(i), 1'b1, 1'b0);
    chk("ovf_fill", {27'd0, fill}, 32'd16);
    chk("ovf_count", {16'd0, ovf}, 32'(exp_ovf));
    chk("ovf_three", {16'd0, ovf}, 32'd3);
    drive(24'd100, 1'b1, 1'b1);
    chk("fullpp_fill", {27'd0, fill}, 32'd16);
    chk("fullpp_ovf", {16'd0, ovf}, 32'd3);
    drain(40);

    // Random backpressure burst
    for (int i = 0; i < 10; i++)
      drive(24'hF00000 | 24'(i * 7), 1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) drive('0, 1'b0, 1'($urandom_range(0, 1)));
    drain(50);

    // Park frame counter at FL-1, buffer 5 words, then reset
    for (int g = 0; g < 8 && mf != FL-1; g++) begin
      drive(24'(g + 50), 1'b1, 1'b1);
      drive('0, 1'b0, 1'b1);
    end
    chk("pre_rst_frame", 32'(mf), 32'(FL-1));
    for (int i = 0; i < 5; i++) drive(24'(i + 200), 1'b1, 1'b0);
    chk("pre_rst_fill", {27'd0, fill}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, tvalid}, 32'd0);
    chk("arst_fill", {27'd0, fill}, 32'd0);
    chk("arst_ovf", {16'd0, ovf}, 32'd0);
    chk("arst_last", {31'd0, tlast}, 32'd0);
    q.delete();
    exp_ovf = 0;
    etag = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(24'h7FFFFF, 1'b1, 1'b1);
    chk("post_rst_last", {31'd0, tlast}, 32'd0);
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
